debounce_scheduler: RTL and testbench

Multi-channel button/switch conditioner for the board I/O path.
- Synchronizes N raw inputs and generates the shared sample tick internally.
- Time-multiplexes a single saturating-count incrementer across all channels in a round-robin sweep.
- Produces debounced levels plus one-cycle press/release pulses for the CPU I/O registers.
- Replaces N free-running per-button debouncers with one scheduled engine.

---
 rtl/debounce_scheduler.sv | 68 ++++++
 tb/tb_debounce_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: multi-channel debouncer sharing one saturating incrementer across a round-robin sweep
module debounce_scheduler #(
  parameter int num_channels = 4,
  parameter int sample_period = 20000,
  parameter int pulse_count_max = 150,
  parameter int counter_width = $clog2(pulse_count_max) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [num_channels-1:0] raw_in,
  output logic [num_channels-1:0] debounced,
  output logic [num_channels-1:0] press_pulse,
  output logic [num_channels-1:0] release_pulse,
  output logic                    sweep_busy
);
  localparam int tw = $clog2(sample_period);
  localparam int iw = num_channels > 1 ? $clog2(num_channels) : 1;
  typedef enum logic {idle, sweep} state_t;
  state_t state;
  logic [tw-1:0] timer;
  logic [iw-1:0] idx;
  logic [num_channels-1:0] s0, sync, sat_nxt;
  logic [counter_width-1:0] count [num_channels];
  logic [counter_width-1:0] count_nxt [num_channels];
  logic tick;
  assign tick = timer == tw'(sample_period - 1);
  assign sweep_busy = state == sweep;
  // a low sample clears the count in any cycle; increments only happen in the channel's own slot
  always_comb begin
    for (int i = 0; i < num_channels; i++) begin
      count_nxt[i] = !sync[i] ? '0
                   : (state == sweep && idx == iw'(i) && count[i] != counter_width'(pulse_count_max)) ? count[i] + 1'b1
                   : count[i];
      sat_nxt[i] = count_nxt[i] == counter_width'(pulse_count_max);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= idle;
      timer <= '0;
      idx <= '0;
      s0 <= '0;
      sync <= '0;
      count <= '{default: '0};
      debounced <= '0;
      press_pulse <= '0;
      release_pulse <= '0;
    end else begin
      s0 <= raw_in;
      sync <= s0;
      timer <= tick ? '0 : timer + 1'b1;
      count <= count_nxt;
      debounced <= sat_nxt;
      press_pulse <= sat_nxt & ~debounced;
      release_pulse <= ~sat_nxt & debounced;
      if (state == idle) begin
        if (tick) begin
          state <= sweep;
          idx <= '0;
        end
      end else if (idx == iw'(num_channels - 1)) begin
        state <= idle;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed checks of the scheduled debouncer with 4 channels, period 8, count 3
`timescale 1ns/1ps
module tb_debounce_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] raw_in = 4'b0;
  logic [3:0] debounced, press_pulse, release_pulse;
  logic sweep_busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  debounce_scheduler #(.num_channels(4), .sample_period(8), .pulse_count_max(3)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .debounced(debounced),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .sweep_busy(sweep_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && dut.tick && sweep_busy) begin
      failures++;
      $error("FAIL tick_in_sweep cyc=%0d obs=1 exp=0", cyc);
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic at(input int c);
    if (cyc < c) begin
      while (cyc < c) begin
        @(posedge clk);
        cyc++;
      end
      #2;
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    raw_in = r;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [3:0] e;
    // press and release on channel 0
    do_reset(4'b0001);
    chk("rst_deb", debounced, 4'b0);
    chk("rst_press", press_pulse, 4'b0);
    chk("rst_release", release_pulse, 4'b0);
    chk("rst_busy", {3'b0, sweep_busy}, 4'b0);
    at(24); chk("s1_deb24", debounced, 4'b0000);
    at(25); chk("s1_deb25", debounced, 4'b0001); chk("s1_press25", press_pulse, 4'b0001);
    at(26); chk("s1_deb26", debounced, 4'b0001); chk("s1_press26", press_pulse, 4'b0000);
    at(40); raw_in = 4'b0000;
    at(42); chk("s2_deb42", debounced, 4'b0001); chk("s2_rel42", release_pulse, 4'b0000);
    at(43); chk("s2_deb43", debounced, 4'b0000); chk("s2_rel43", release_pulse, 4'b0001);
    at(44); chk("s2_rel44", release_pulse, 4'b0000); chk("s2_press44", press_pulse, 4'b0000);
    // one-cycle glitch on channel 1 restarts its count
    do_reset(4'b0010);
    at(13); raw_in = 4'b0000;
    at(14); raw_in = 4'b0010;
    at(26); chk("s3_deb26", debounced, 4'b0000); chk("s3_press26", press_pulse, 4'b0000);
    at(33); chk("s3_deb33", debounced, 4'b0000);
    at(34); chk("s3_deb34", debounced, 4'b0010); chk("s3_press34", press_pulse, 4'b0010);
    // all channels high: staggered rises and sweep windows
    do_reset(4'b1111);
    for (int c = 0; c <= 30; c++) begin
      at(c);
      chk("s4_busy", {3'b0, sweep_busy},
          {3'b0, (c >= 8 && c <= 11) || (c >= 16 && c <= 19) || (c >= 24 && c <= 27)});
      for (int i = 0; i < 4; i++) e[i] = c >= 25 + i;
      chk("s4_deb", debounced, e);
      for (int i = 0; i < 4; i++) e[i] = c == 25 + i;
      chk("s4_press", press_pulse, e);
    end
    // reset in the middle of a sweep
    do_reset(4'b1111);
    at(18); chk("s5_busy18", {3'b0, sweep_busy}, 4'b0001);
    rst = 1'b1;
    at(19);
    rst = 1'b0;
    cyc = 0;
    chk("s5_deb0", debounced, 4'b0);
    chk("s5_busy0", {3'b0, sweep_busy}, 4'b0);
    chk("s5_press0", press_pulse, 4'b0);
    at(7); chk("s5_busy7", {3'b0, sweep_busy}, 4'b0);
    at(8); chk("s5_busy8", {3'b0, sweep_busy}, 4'b0001);
    at(9); chk("s5_deb9", debounced, 4'b0);
    at(24); chk("s5_deb24", debounced, 4'b0);
    at(25); chk("s5_deb25", debounced, 4'b0001);
    // channel 2 held for ten sweeps stays saturated with one press
    do_reset(4'b0100);
    for (int c = 0; c <= 95; c++) begin
      at(c);
      chk("s6_deb", debounced, c >= 27 ? 4'b0100 : 4'b0000);
      chk("s6_press", press_pulse, c == 27 ? 4'b0100 : 4'b0000);
      chk("s6_rel", release_pulse, 4'b0000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
